// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer.
// States, instruction classes, opcodes and datapath select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JR        = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    IC_LOAD,
    IC_STORE,
    IC_RTYPE,
    IC_JR,
    IC_ITYPE,
    IC_BRANCH,
    IC_JUMP,
    IC_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] AOP_ADD   = 2'd0;
  localparam logic [1:0] AOP_SUB   = 2'd1;
  localparam logic [1:0] AOP_FUNCT = 2'd2;
  localparam logic [1:0] AOP_IMM   = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] MR_ALU = 2'd0;
  localparam logic [1:0] MR_MDR = 2'd1;
  localparam logic [1:0] MR_PC  = 2'd2;

endpackage

// File: rtl/mc_opdecode.sv
// Opcode/funct to instruction-class decoder.
// Purely combinational; the sequencer dispatches on the class.
module mc_opdecode
  import multicycle_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  logic is_r;

  assign is_r = (opcode == OP_RTYPE);

  always_comb begin
    iclass = IC_ILLEGAL;
    unique case (1'b1)
      (opcode == OP_LW):
        iclass = IC_LOAD;
      (opcode == OP_SW):
        iclass = IC_STORE;
      (is_r && funct == FN_JR):
        iclass = IC_JR;
      (is_r && funct != FN_JR):
        iclass = IC_RTYPE;
      (opcode inside {OP_ADDI, OP_SLTI,
                      OP_ANDI, OP_ORI}):
        iclass = IC_ITYPE;
      (opcode inside {OP_BEQ, OP_BNE}):
        iclass = IC_BRANCH;
      (opcode inside {OP_J, OP_JAL}):
        iclass = IC_JUMP;
      default:
        iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer with handshaked, variable-latency memory.
// Outputs are decoded from state; a wait counter bounds memory stalls.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       halted,
  output logic [3:0] state
);

  localparam int CW =
    (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  state_t        cur;
  state_t        nxt;
  iclass_t       iclass;
  logic [CW-1:0] wait_cnt;
  logic          waiting;
  logic          timeout;

  mc_opdecode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass)
  );

  assign state = cur;

  // Last permitted wait cycle; MEM_WAIT_MAX of 0 never times out.
  assign timeout = (MEM_WAIT_MAX != 0) &&
    (int'(wait_cnt) == MEM_WAIT_MAX - 1);

  always_comb begin
    nxt     = cur;
    waiting = 1'b0;
    unique case (cur)
      S_FETCH:
        if (mem_ready) nxt = S_DECODE;
        else waiting = 1'b1;
      S_DECODE:
        unique case (iclass)
          IC_LOAD, IC_STORE: nxt = S_MEM_ADDR;
          IC_RTYPE:          nxt = S_EXEC_R;
          IC_JR:             nxt = S_JR;
          IC_ITYPE:          nxt = S_EXEC_I;
          IC_BRANCH:         nxt = S_BRANCH;
          IC_JUMP:           nxt = S_JUMP;
          default:           nxt = S_HALT;
        endcase
      S_MEM_ADDR:
        nxt = (iclass == IC_LOAD) ? S_MEM_READ
                                  : S_MEM_WRITE;
      S_MEM_READ:
        if (mem_ready) nxt = S_MEM_WB;
        else waiting = 1'b1;
      S_MEM_WRITE:
        if (mem_ready) nxt = S_FETCH;
        else waiting = 1'b1;
      S_EXEC_R, S_EXEC_I:
        nxt = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH,
      S_JUMP, S_JR:
        nxt = S_FETCH;
      S_HALT:
        nxt = S_HALT;
      default:
        nxt = S_HALT;
    endcase
    if (waiting && timeout) nxt = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = AOP_ADD;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = MR_ALU;
    halted     = 1'b0;
    unique case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE:
        alu_src_b = SRCB_IMMSH;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_ready;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = MR_MDR;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_FUNCT;
        reg_dst   = RD_RD;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = AOP_IMM;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (iclass == IC_RTYPE) ? RD_RD
                                         : RD_RT;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_SUB;
        pc_src    = PC_ALUOUT;
        pc_en     = zero ^ (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_en  = 1'b1;
        pc_src = PC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = RD_RA;
          mem_to_reg = MR_PC;
        end
      end
      S_JR: begin
        pc_en  = 1'b1;
        pc_src = PC_RS;
      end
      S_HALT:
        halted = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Instance uses MEM_WAIT_MAX=4 so the timeout is reachable quickly.
module tb_multicycle_control;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       mdr_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       halted;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control #(.MEM_WAIT_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .mdr_write  (mdr_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want %0d",
               state, S_FETCH);
    end
    n_checks++;
    if ({mem_req, ir_write, pc_en, halted} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_gating: got %b want 0000",
               {mem_req, ir_write, pc_en, halted});
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, iord, alu_src_b} !== 4'b1001) begin
      n_fail++;
      $display("FAIL fetch_out: got %b want 1001",
               {mem_req, iord, alu_src_b});
    end
  endtask

  task automatic test_lw();
    state_t exp [6];
    exp = '{S_FETCH, S_DECODE, S_MEM_ADDR,
            S_MEM_READ, S_MEM_WB, S_FETCH};
    opcode = OP_LW; funct = 6'h00; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== exp[i]) begin
        n_fail++;
        $display("FAIL lw_state[%0d]: got %0d want %0d",
                 i, state, exp[i]);
      end
    end
  endtask

  task automatic test_lw_outputs();
    opcode = OP_LW; mem_ready = 1'b1;
    step(); step(); step();
    n_checks++;
    if ({mem_req, iord, mdr_write} !== 3'b111) begin
      n_fail++;
      $display("FAIL lw_read: got %b want 111",
               {mem_req, iord, mdr_write});
    end
    step();
    n_checks++;
    if ({reg_write, mem_to_reg, reg_dst} !== 5'b10100) begin
      n_fail++;
      $display("FAIL lw_wb: got %b want 10100",
               {reg_write, mem_to_reg, reg_dst});
    end
    step();
  endtask

  task automatic test_sw();
    state_t exp [5];
    exp = '{S_FETCH, S_DECODE, S_MEM_ADDR,
            S_MEM_WRITE, S_FETCH};
    opcode = OP_SW; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== exp[i]) begin
        n_fail++;
        $display("FAIL sw_state[%0d]: got %0d want %0d",
                 i, state, exp[i]);
      end
      if (i == 3) begin
        n_checks++;
        if ({mem_req, mem_we, iord} !== 3'b111) begin
          n_fail++;
          $display("FAIL sw_write: got %b want 111",
                   {mem_req, mem_we, iord});
        end
      end
    end
  endtask

  task automatic test_alu_ops();
    opcode = OP_RTYPE; funct = 6'h20; mem_ready = 1'b1;
    step(); step();
    n_checks++;
    if (state !== S_EXEC_R || alu_op !== AOP_FUNCT) begin
      n_fail++;
      $display("FAIL r_exec: got st=%0d op=%0d want %0d/2",
               state, alu_op, S_EXEC_R);
    end
    step();
    n_checks++;
    if ({state, reg_write, reg_dst} !== {S_ALU_WB, 3'b101}) begin
      n_fail++;
      $display("FAIL r_wb: got st=%0d rw=%b rd=%0d",
               state, reg_write, reg_dst);
    end
    step();
    opcode = OP_ORI;
    step(); step();
    n_checks++;
    if ({state, alu_src_b, alu_op} !== {S_EXEC_I, 4'b1011}) begin
      n_fail++;
      $display("FAIL i_exec: got st=%0d b=%0d op=%0d",
               state, alu_src_b, alu_op);
    end
    step();
    n_checks++;
    if ({state, reg_write, reg_dst} !== {S_ALU_WB, 3'b100}) begin
      n_fail++;
      $display("FAIL i_wb: got st=%0d rw=%b rd=%0d",
               state, reg_write, reg_dst);
    end
    step();
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL i_done: got %0d want %0d", state, S_FETCH);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3];
    logic       zs  [3];
    logic       pe  [3];
    ops = '{OP_BEQ, OP_BNE, OP_BEQ};
    zs  = '{1'b1, 1'b1, 1'b0};
    pe  = '{1'b1, 1'b0, 1'b0};
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = ops[i]; zero = zs[i];
      step(); step();
      n_checks++;
      if ({state, pc_en, pc_src, alu_op} !==
          {S_BRANCH, pe[i], 4'b0101}) begin
        n_fail++;
        $display("FAIL branch[%0d]: got st=%0d en=%b src=%0d",
                 i, state, pc_en, pc_src);
      end
      step();
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    opcode = OP_JAL; mem_ready = 1'b1;
    step(); step();
    n_checks++;
    if ({state, pc_en, pc_src, reg_write, reg_dst, mem_to_reg}
        !== {S_JUMP, 8'b1_10_1_10_10}) begin
      n_fail++;
      $display("FAIL jal: got st=%0d %b%b%b%b%b", state, pc_en,
               pc_src, reg_write, reg_dst, mem_to_reg);
    end
    step();
    opcode = OP_J;
    step(); step();
    n_checks++;
    if ({state, pc_en, pc_src, reg_write}
        !== {S_JUMP, 4'b1100}) begin
      n_fail++;
      $display("FAIL j: got st=%0d en=%b src=%0d rw=%b",
               state, pc_en, pc_src, reg_write);
    end
    step();
    opcode = OP_RTYPE; funct = FN_JR;
    step(); step();
    n_checks++;
    if ({state, pc_en, pc_src} !== {S_JR, 3'b111}) begin
      n_fail++;
      $display("FAIL jr: got st=%0d en=%b src=%0d",
               state, pc_en, pc_src);
    end
    step();
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL jr_done: got %0d want %0d", state, S_FETCH);
    end
  endtask

  task automatic test_fetch_wait();
    opcode = OP_J; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      if (i == 3) mem_ready = 1'b1;
      #1;
      n_checks++;
      if ({state, mem_req, ir_write, pc_en} !==
          {S_FETCH, 1'b1, (i == 3), (i == 3)}) begin
        n_fail++;
        $display("FAIL fetch_wait[%0d]: got st=%0d %b%b%b",
                 i, state, mem_req, ir_write, pc_en);
      end
    end
    step();
    n_checks++;
    if (state !== S_DECODE) begin
      n_fail++;
      $display("FAIL fetch_wait_go: got %0d want %0d",
               state, S_DECODE);
    end
    step(); step();
  endtask

  task automatic test_illegal();
    opcode = 6'h3F; mem_ready = 1'b1;
    step(); step();
    n_checks++;
    if ({state, halted} !== {S_HALT, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal: got st=%0d h=%b", state, halted);
    end
    step(); step();
    n_checks++;
    if ({state, halted, mem_req, pc_en, reg_write}
        !== {S_HALT, 4'b1000}) begin
      n_fail++;
      $display("FAIL halt_hold: got st=%0d %b%b%b%b", state,
               halted, mem_req, pc_en, reg_write);
    end
    do_reset();
    n_checks++;
    if ({state, halted} !== {S_FETCH, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_exit: got st=%0d h=%b", state, halted);
    end
  endtask

  task automatic test_timeout();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++;
      if (state !== ((i < 4) ? S_FETCH : S_HALT)) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got %0d", i, state);
      end
    end
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_halted: got %b want 1", halted);
    end
    mem_ready = 1'b1;
    do_reset();
  endtask

  task automatic test_reset_mid();
    opcode = OP_SW; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    step(); step(); step();
    n_checks++;
    if ({state, mem_we} !== {S_MEM_WRITE, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_pre: got st=%0d we=%b", state, mem_we);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({state, mem_we} !== {S_FETCH, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_rst: got st=%0d we=%b", state, mem_we);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++;
      if (state !== ((i < 4) ? S_FETCH : S_HALT)) begin
        n_fail++;
        $display("FAIL mid_cnt[%0d]: got %0d", i, state);
      end
    end
    mem_ready = 1'b1;
    do_reset();
  endtask

  initial begin
    reset = 1'b0; opcode = 6'h00; funct = 6'h00;
    zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_lw_outputs();
    test_sw();
    test_alu_ops();
    test_branch();
    test_jumps();
    test_fetch_wait();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
